cpu_dispatcher: RTL and testbench

- Central arbiter on the external side of every per-CPU bridge; sits directly downstream of the bridges' ext_* interface.
- Enumerates CPUs after reset by daisy-chaining indices.
- Rotates the bus token round-robin using the next-CPU handshake.
- Turns a token-holder's read or write request into a single memory transaction and returns the done strobes.

---
 rtl/cpu_dispatcher_pkg.sv | 22 ++
 rtl/cpu_dispatcher_if.sv | 38 +++
 rtl/dispatcher_rr_counter.sv | 48 ++++
 rtl/cpu_dispatcher.sv | 146 ++++++++++++++
 tb/tb_cpu_dispatcher.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_dispatcher_pkg.sv
// Shared definitions for the CPU dispatcher: FSM states, index width helper
// and the reset-chain message constants already used by the bridges.
package cpu_dispatcher_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENUM,
    S_OFFER,
    S_ACCESS,
    S_RESP,
    S_RELEASE,
    S_ADVANCE
  } state_e;

  localparam logic [31:0] CPU_R_START = 32'h5253_5442;
  localparam logic [31:0] CPU_R_END   = 32'h5253_5445;

  function automatic int unsigned idx_w(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/cpu_dispatcher_if.sv
// Token/bus handshake between the bridges and the dispatcher, plus the
// dispatcher's memory port. master = dispatcher side.
interface cpu_dispatcher_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) ();

  logic              ext_next_cpu_q;
  logic              ext_next_cpu_e;
  logic              ext_read_q;
  logic              ext_write_q;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              read_dn;
  logic              write_dn;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output ext_next_cpu_q, bus_rdata, read_dn, write_dn,
           mem_req, mem_we, mem_addr, mem_wdata,
    input  ext_next_cpu_e, ext_read_q, ext_write_q, bus_addr, bus_wdata,
           mem_rdata, mem_ack
  );

  modport slave (
    input  ext_next_cpu_q, bus_rdata, read_dn, write_dn,
           mem_req, mem_we, mem_addr, mem_wdata,
    output ext_next_cpu_e, ext_read_q, ext_write_q, bus_addr, bus_wdata,
           mem_rdata, mem_ack
  );

endinterface

// File: rtl/dispatcher_rr_counter.sv
// Round-robin token index with wrap against the enumerated CPU count,
// plus the unanswered-offer timer.
module dispatcher_rr_counter #(
  parameter int unsigned IW       = 3,
  parameter int unsigned OFFER_TO = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          advance,
  input  logic          offer_active,
  input  logic [IW-1:0] num_cpus,
  output logic [IW-1:0] cur,
  output logic          timeout
);

  localparam int unsigned     TW      = $clog2(OFFER_TO) + 1;
  localparam logic [TW-1:0]   TO_LAST = TW'(OFFER_TO - 1);

  logic [IW-1:0] cur_q, cur_d, cur_inc;
  logic [TW-1:0] timer_q, timer_d;

  always_comb begin
    cur_inc = cur_q + IW'(1);
    cur_d   = cur_q;
    if (clear) begin
      cur_d = '0;
    end else if (advance) begin
      cur_d = (cur_inc == num_cpus) ? '0 : cur_inc;
    end
    // Timer restarts on every fresh offer since any other state zeroes it.
    timer_d = offer_active ? timer_q + TW'(1) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q   <= '0;
      timer_q <= '0;
    end else begin
      cur_q   <= cur_d;
      timer_q <= timer_d;
    end
  end

  assign cur     = cur_q;
  assign timeout = offer_active && (timer_q == TO_LAST);

endmodule

// File: rtl/cpu_dispatcher.sv
// Central arbiter behind the per-CPU bridges: enumerates the reset chain,
// rotates the bus token and turns token-holder requests into memory accesses.
module cpu_dispatcher #(
  parameter int unsigned NUM_CPUS = 4,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned OFFER_TO = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              ext_rst_b,
  input  logic              ext_rst_e,
  input  logic              enum_ack,
  output logic [DATA_W-1:0] cpu_index_o,
  output logic              cpu_index_oe,
  output logic [7:0]        num_cpus,
  cpu_dispatcher_if.master  bus
);

  import cpu_dispatcher_pkg::*;

  localparam int unsigned   IW      = idx_w(NUM_CPUS);
  localparam logic [IW-1:0] MAX_CNT = IW'(NUM_CPUS);

  state_e            state_q, state_d;
  logic [IW-1:0]     cnt_q, cnt_d, cnt_next, num_q, num_d, cur;
  logic              parked_q, parked_d, ext_rst_b_q, ext_rst_b_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic              req, clear, advance, timeout;

  dispatcher_rr_counter #(.IW(IW), .OFFER_TO(OFFER_TO)) u_rr (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .advance      (advance),
    .offer_active (state_q == S_OFFER),
    .num_cpus     (num_q),
    .cur          (cur),
    .timeout      (timeout)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    num_d       = num_q;
    parked_d    = parked_q;
    ext_rst_b_d = 1'b0;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    clear       = 1'b0;
    advance     = 1'b0;
    req         = bus.ext_read_q | bus.ext_write_q;
    cnt_next    = cnt_q + IW'(enum_ack);

    case (state_q)
      S_IDLE: begin
        if (!parked_q) begin
          ext_rst_b_d = 1'b1;
          cnt_d       = '0;
          state_d     = S_ENUM;
        end
      end
      S_ENUM: begin
        // A same-cycle ack is folded into the count before finishing.
        cnt_d = cnt_next;
        if (ext_rst_e || (cnt_next == MAX_CNT)) begin
          num_d = cnt_next;
          clear = 1'b1;
          if (cnt_next == '0) begin
            parked_d = 1'b1;
            state_d  = S_IDLE;
          end else begin
            state_d = S_OFFER;
          end
        end
      end
      S_OFFER, S_RELEASE: begin
        if (req) begin
          addr_d  = bus.bus_addr;
          wdata_d = bus.bus_wdata;
          we_d    = bus.ext_write_q & ~bus.ext_read_q;
          state_d = S_ACCESS;
        end else if (bus.ext_next_cpu_e) begin
          state_d = S_ADVANCE;
        end else if ((state_q == S_OFFER) && timeout) begin
          state_d = S_ADVANCE;
        end
      end
      S_ACCESS: begin
        if (bus.mem_ack) begin
          if (!we_q) rdata_d = bus.mem_rdata;
          state_d = S_RESP;
        end
      end
      S_RESP:    state_d = S_RELEASE;
      S_ADVANCE: begin
        advance = 1'b1;
        state_d = S_OFFER;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      num_q       <= '0;
      parked_q    <= 1'b0;
      ext_rst_b_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      num_q       <= num_d;
      parked_q    <= parked_d;
      ext_rst_b_q <= ext_rst_b_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign ext_rst_b    = ext_rst_b_q;
  assign cpu_index_oe = (state_q != S_IDLE);
  assign cpu_index_o  = (state_q == S_IDLE) ? '0 :
                        (state_q == S_ENUM) ? DATA_W'(cnt_q) : DATA_W'(cur);
  assign num_cpus     = 8'(num_q);

  assign bus.ext_next_cpu_q = state_q inside {S_OFFER, S_ACCESS, S_RESP, S_RELEASE};
  assign bus.mem_req        = (state_q == S_ACCESS);
  assign bus.mem_we         = (state_q == S_ACCESS) && we_q;
  assign bus.mem_addr       = addr_q;
  assign bus.mem_wdata      = wdata_q;
  assign bus.bus_rdata      = rdata_q;
  assign bus.read_dn        = (state_q == S_RESP) && !we_q;
  assign bus.write_dn       = (state_q == S_RESP) && we_q;

endmodule

// File: tb/tb_cpu_dispatcher.sv
// Directed + randomized bench for cpu_dispatcher against a behavioural model
// of enumeration count, token rotation order and a word-addressed memory.
module tb_cpu_dispatcher;

  localparam int unsigned NCPU = 4;
  localparam int unsigned OTO  = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ext_rst_b, ext_rst_e, enum_ack, cpu_index_oe;
  logic [31:0] cpu_index_o;
  logic [7:0]  num_cpus;

  cpu_dispatcher_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  cpu_dispatcher #(.NUM_CPUS(NCPU), .DATA_W(32), .ADDR_W(32), .OFFER_TO(OTO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ext_rst_b    (ext_rst_b),
    .ext_rst_e    (ext_rst_e),
    .enum_ack     (enum_ack),
    .cpu_index_o  (cpu_index_o),
    .cpu_index_oe (cpu_index_oe),
    .num_cpus     (num_cpus),
    .bus          (bus.master)
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned n_model = 0;
  int unsigned cur_model = 0;
  logic [31:0] exp_rdata = '0;
  logic [31:0] mem [logic [31:0]];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ext_rst_e = 1'b0; enum_ack = 1'b0;
    bus.ext_next_cpu_e = 1'b0; bus.ext_read_q = 1'b0; bus.ext_write_q = 1'b0;
    bus.bus_addr = '0; bus.bus_wdata = '0; bus.mem_rdata = '0; bus.mem_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    exp_rdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  // kind: 0 read, 1 write, 2 read+write together (read must win)
  task automatic access(input int unsigned kind, input logic [31:0] a,
                        input logic [31:0] wd, input int unsigned dly);
    bit is_wr;
    logic [31:0] rd;
    is_wr = (kind == 1);
    bus.ext_read_q = (kind != 1); bus.ext_write_q = (kind != 0);
    bus.bus_addr = a; bus.bus_wdata = wd;
    step();
    bus.ext_read_q = 1'b0; bus.ext_write_q = 1'b0;
    bus.bus_addr = $urandom; bus.bus_wdata = $urandom;
    chk("mem_req", bus.mem_req, 1);
    chk("mem_we", bus.mem_we, is_wr);
    chk("mem_addr", bus.mem_addr, a);
    if (is_wr) chk("mem_wdata", bus.mem_wdata, wd);
    for (int unsigned i = 0; i < dly; i++) begin
      step();
      chk("mem_req_hold", bus.mem_req, 1);
      chk("mem_addr_hold", bus.mem_addr, a);
    end
    if (!is_wr && !mem.exists(a)) mem[a] = $urandom;
    rd = is_wr ? 32'($urandom) : mem[a];
    bus.mem_ack = 1'b1; bus.mem_rdata = rd;
    step();
    bus.mem_ack = 1'b0; bus.mem_rdata = $urandom;
    if (is_wr) mem[a] = wd; else exp_rdata = rd;
    chk("read_dn", bus.read_dn, !is_wr);
    chk("write_dn", bus.write_dn, is_wr);
    chk("mem_req_drop", bus.mem_req, 0);
    chk("bus_rdata", bus.bus_rdata, exp_rdata);
    step();
    chk("dn_clear", {bus.read_dn, bus.write_dn}, 0);
    chk("hold_token", bus.ext_next_cpu_q, 1);
    chk("bus_rdata_keep", bus.bus_rdata, exp_rdata);
  endtask

  task automatic release_tok();
    bus.ext_next_cpu_e = 1'b1;
    step();
    bus.ext_next_cpu_e = 1'b0;
    chk("advance_q", bus.ext_next_cpu_q, 0);
    step();
    cur_model = (cur_model + 1) % n_model;
    chk("offer_q", bus.ext_next_cpu_q, 1);
    chk("offer_idx", cpu_index_o, cur_model);
    chk("offer_oe", cpu_index_oe, 1);
  endtask

  task automatic offer_timeout();
    for (int unsigned c = 0; c < OTO; c++) begin
      chk("to_offer_q", bus.ext_next_cpu_q, 1);
      chk("to_offer_idx", cpu_index_o, cur_model);
      step();
    end
    chk("to_advance_q", bus.ext_next_cpu_q, 0);
    step();
    cur_model = (cur_model + 1) % n_model;
  endtask

  task automatic random_slot();
    int unsigned ntx;
    if ($urandom_range(0, 3) == 0) begin
      offer_timeout();
      chk("to_next_idx", cpu_index_o, cur_model);
    end else begin
      ntx = $urandom_range(1, 2);
      for (int unsigned t = 0; t < ntx; t++)
        access($urandom_range(0, 2), {24'h0, 8'($urandom_range(0, 15))}, $urandom,
               $urandom_range(0, 3));
      release_tok();
    end
  endtask

  // Entered at the first cycle after reset release.
  task automatic run_enum(input int unsigned nack, input bit end_with_ack);
    int unsigned given = 0;
    bit done = 1'b0;
    chk("enum_rst_b", ext_rst_b, 1);
    chk("enum_oe", cpu_index_oe, 1);
    chk("enum_idx0", cpu_index_o, 0);
    for (int unsigned i = 0; i < nack; i++) begin
      repeat ($urandom_range(0, 2)) begin
        step();
        chk("enum_rst_b_low", ext_rst_b, 0);
        chk("enum_idx", cpu_index_o, given);
      end
      enum_ack = 1'b1;
      ext_rst_e = end_with_ack && (i == nack - 1);
      step();
      enum_ack = 1'b0; ext_rst_e = 1'b0;
      given++;
      if (given == NCPU || (end_with_ack && i == nack - 1)) done = 1'b1;
      else chk("enum_idx_step", cpu_index_o, given);
    end
    if (!done) begin
      ext_rst_e = 1'b1;
      step();
      ext_rst_e = 1'b0;
    end
    n_model = given;
    cur_model = 0;
    chk("num_cpus", num_cpus, given);
    if (given != 0) begin
      chk("first_offer_q", bus.ext_next_cpu_q, 1);
      chk("first_offer_idx", cpu_index_o, 0);
    end else begin
      repeat (4) begin
        chk("parked_q", bus.ext_next_cpu_q, 0);
        chk("parked_oe", cpu_index_oe, 0);
        chk("parked_rst_b", ext_rst_b, 0);
        chk("parked_num", num_cpus, 0);
        step();
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    chk("rst_rst_b", ext_rst_b, 0);
    chk("rst_oe", cpu_index_oe, 0);
    chk("rst_idx", cpu_index_o, 0);
    chk("rst_num", num_cpus, 0);
    chk("rst_outs", {bus.ext_next_cpu_q, bus.mem_req, bus.mem_we, bus.read_dn, bus.write_dn}, 0);
    chk("rst_rdata", bus.bus_rdata, 0);

    // Directed enumeration: acks in cycles 3,5,7, chain end in cycle 8.
    @(negedge clk);
    rst_n = 1'b1;
    step();
    begin
      int unsigned acks = 0;
      for (int unsigned k = 1; k <= 8; k++) begin
        chk("denum_rst_b", ext_rst_b, (k == 1));
        chk("denum_oe", cpu_index_oe, 1);
        chk("denum_idx", cpu_index_o, acks);
        enum_ack = (k == 3 || k == 5 || k == 7);
        ext_rst_e = (k == 8);
        if (enum_ack) acks++;
        step();
      end
      enum_ack = 1'b0; ext_rst_e = 1'b0;
    end
    n_model = 3; cur_model = 0;
    chk("denum_num", num_cpus, 3);
    chk("denum_offer_q", bus.ext_next_cpu_q, 1);
    chk("denum_offer_idx", cpu_index_o, 0);

    // CPU0 read, CPU1 write, CPU2 read/write conflict.
    mem[32'h100] = 32'hDEADBEEF;
    access(0, 32'h100, 32'h0, 2);
    chk("dir_rdata", bus.bus_rdata, 32'hDEADBEEF);
    release_tok();
    access(1, 32'h20, 32'h55, 1);
    release_tok();
    chk("dir_after_wr_idx", cpu_index_o, 2);
    access(2, 32'h20, 32'h77, 0);
    chk("conflict_rdata", bus.bus_rdata, 32'h55);
    release_tok();

    // Unanswered offers rotate 0,1,2,0,1 and land on 2.
    for (int unsigned o = 0; o < 5; o++) offer_timeout();
    chk("to_wrap_idx", cpu_index_o, 2);

    repeat (12) random_slot();

    // Reset while a memory access is outstanding.
    bus.ext_read_q = 1'b1; bus.bus_addr = 32'h4;
    step();
    bus.ext_read_q = 1'b0;
    chk("mid_mem_req", bus.mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_mem_req", bus.mem_req, 0);
    chk("async_dn", {bus.read_dn, bus.write_dn}, 0);
    chk("async_num", num_cpus, 0);
    chk("async_q", bus.ext_next_cpu_q, 0);
    idle_inputs();
    exp_rdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();
    run_enum(0, 1'b0);

    do_reset();
    run_enum(NCPU, 1'b0);
    repeat (8) random_slot();

    do_reset();
    run_enum(2, 1'b1);
    repeat (6) random_slot();

    do_reset();
    run_enum(1, 1'b1);
    repeat (4) random_slot();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
